usb_tx_sequencer: RTL and testbench
===================================

USB_TX_SEQUENCER -- requirements
Module: usb_tx_sequencer

Interface
REQ-001 Parameter: none; field widths fixed by the USB 2.0 FS packet format.
REQ-002 clk  in  1  single system clock, one bit time per enabled cycle.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 start  in  1  one-cycle request; sampled only in IDLE.
REQ-005 pkt_type  in  2  00 handshake, 01 token, 10 data, 11 reserved (start ignored).
REQ-006 pid  in  4  PID, captured with start.
REQ-007 tok_field  in  11  {endp[3:0], addr[6:0]}, captured with start.
REQ-008 byte_data  in  8  payload byte.
REQ-009 byte_valid  in  1  payload byte available.
REQ-010 byte_last  in  1  qualifies byte_data as final payload byte.
REQ-011 byte_ready  out  1  one-cycle accept strobe for byte_data.
REQ-012 stuff_hold  in  1  stuffer inserting a bit; sequencer freezes this cycle.
REQ-013 tx_bit  out  1  serial bit to the bit stuffer data_in.
REQ-014 tx_en  out  1  tx_bit valid; drives the stuffer en_data.
REQ-015 eop  out  1  high during the 2 EOP cycles.
REQ-016 busy  out  1  high in every non-IDLE state.
REQ-017 done  out  1  one-cycle pulse on the last EOP cycle.
REQ-018 underrun  out  1  one-cycle pulse when a data byte is missing.

Function
REQ-019 States: IDLE, SYNC, PID, TOKEN, DATA, CRC, EOP.
REQ-020 IDLE→SYNC on start with valid pkt_type; start while busy is ignored.
REQ-021 First SYNC bit on tx_bit in the cycle after start; SYNC = 0,0,0,0,0,0,0,1.
REQ-022 PID byte = {~pid, pid}, sent LSB first; 8 bits.
REQ-023 After PID: handshake→EOP, token→TOKEN, data→DATA.
REQ-024 TOKEN sends tok_field LSB first, 11 bits, then CRC (5 bits).
REQ-025 DATA sends bytes LSB first; byte accepted (byte_ready) on the cycle its bit 0 is output.
REQ-026 First data byte requested in the last PID cycle; byte_valid low then → zero-length packet, go to CRC directly.
REQ-027 After a byte with byte_last=1 completes → CRC (16 bits); otherwise next byte requested at bit 7.
REQ-028 byte_valid low when a non-first byte is required → underrun pulse, CRC skipped, go to EOP.
REQ-029 CRC5: poly x^5+x^2+1, init 5'h1F, over tok_field bits in transmit order; inverted result sent MSB first.
REQ-030 CRC16: poly 16'h8005, init 16'hFFFF, over payload bits in transmit order; inverted result sent MSB first.
REQ-031 CRC updates only on cycles where a payload/token bit is emitted and stuff_hold=0.
REQ-032 stuff_hold=1: tx_en=0, no counter, CRC or state advance; tx_bit holds its value; ignored in IDLE and EOP.
REQ-033 tx_en=1 exactly in SYNC/PID/TOKEN/DATA/CRC cycles with stuff_hold=0.
REQ-034 EOP: tx_en=0, eop=1 for 2 cycles, done on the second, then IDLE.
REQ-035 Bit counter 4 bits wraps per field; no field exceeds 16 bits.

Reset
REQ-036 rst low: state IDLE; tx_bit=1, tx_en=0, eop=0, busy=0, done=0, underrun=0, byte_ready=0, counters and CRC cleared.
REQ-037 Reset mid-packet aborts immediately; no EOP, no done.

Structure
REQ-038 Shared package holds state encoding, pkt_type codes, SYNC pattern, CRC polynomials and init values.
REQ-039 One sub-module usb_crc_gen: serial CRC5/CRC16 with init, enable, mode select.
REQ-040 Top sequencer FSM instantiates usb_crc_gen once; its tx_bit/tx_en feed bit_stuffing data_in/en_data.

Verification
REQ-041 ACK: pkt_type=00, pid=4'b0010 → 8 SYNC bits, then 0,1,0,0,1,0,1,1; 16 tx_en cycles, eop 2 cycles, done.
REQ-042 SETUP token: pid=4'b1101, tok_field=0 → wire bytes 0x2D,0x00,0x10 LSB first after SYNC (CRC5 bits 0,1,0,0,0).
REQ-043 DATA0 zero-length: pid=4'b0011, byte_valid=0 → PID 0xC3 then 16 zero CRC bits, EOP, no underrun.
REQ-044 DATA0 two bytes with byte_last on the second, stuff_hold pulsed once mid-byte → exactly 2 byte_ready pulses; tx stream equals a software CRC16 model output; one-cycle freeze.
REQ-045 Underrun: byte_valid dropped before byte 2 → underrun pulse, no CRC bits, EOP, done.
REQ-046 rst low during DATA → all outputs at reset values next cycle; new start after release sends a clean packet.

Source files
------------

// File: rtl/usb_tx_sequencer_pkg.sv
// Shared types and constants for the USB full-speed packet transmit sequencer.
// Holds the state encoding, packet type codes, SYNC pattern and the CRC parameters.
package usb_tx_sequencer_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSync,
    StPid,
    StToken,
    StData,
    StCrc,
    StEop
  } state_t;

  typedef enum logic [1:0] {
    PktHandshake = 2'b00,
    PktToken     = 2'b01,
    PktData      = 2'b10,
    PktReserved  = 2'b11
  } pkt_type_t;

  // SYNC is sent LSB first: seven zeros followed by a one.
  localparam logic [7:0]  SyncPattern = 8'h80;
  localparam logic [4:0]  Crc5Poly    = 5'h05;
  localparam logic [4:0]  Crc5Init    = 5'h1F;
  localparam logic [15:0] Crc16Poly   = 16'h8005;
  localparam logic [15:0] Crc16Init   = 16'hFFFF;
  localparam logic [3:0]  TokLastBit  = 4'd10;

  function automatic logic [7:0] pid_byte(input logic [3:0] pid);
    return {~pid, pid};
  endfunction

endpackage

// File: rtl/usb_tx_sequencer_if.sv
// Request, payload and serial-output signals between a packet source and the sequencer.
// The slave modport is the sequencer side; the master modport is the packet source side.
interface usb_tx_sequencer_if;
  logic        start;
  logic [1:0]  pkt_type;
  logic [3:0]  pid;
  logic [10:0] tok_field;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic        byte_last;
  logic        byte_ready;
  logic        stuff_hold;
  logic        tx_bit;
  logic        tx_en;
  logic        eop;
  logic        busy;
  logic        done;
  logic        underrun;

  modport master (
    output start, pkt_type, pid, tok_field, byte_data, byte_valid, byte_last, stuff_hold,
    input  byte_ready, tx_bit, tx_en, eop, busy, done, underrun
  );

  modport slave (
    input  start, pkt_type, pid, tok_field, byte_data, byte_valid, byte_last, stuff_hold,
    output byte_ready, tx_bit, tx_en, eop, busy, done, underrun
  );
endinterface

// File: rtl/usb_crc_gen.sv
// Serial USB CRC generator: CRC5 (x^5+x^2+1) or CRC16 (0x8005), one data bit per enabled cycle.
// The register is left uninverted; the sequencer inverts it while shifting it out.
module usb_crc_gen
  import usb_tx_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        init,
  input  logic        en,
  input  logic        mode16,
  input  logic        din,
  output logic [15:0] crc
);

  logic [15:0] crc_q, crc_d;
  logic        fb;

  always_comb begin
    crc_d = crc_q;
    fb    = 1'b0;
    if (init) begin
      crc_d = mode16 ? Crc16Init : {11'd0, Crc5Init};
    end else if (en) begin
      if (mode16) begin
        fb    = crc_q[15] ^ din;
        crc_d = {crc_q[14:0], 1'b0} ^ (fb ? Crc16Poly : 16'h0000);
      end else begin
        fb    = crc_q[4] ^ din;
        crc_d = {11'd0, crc_q[3:0], 1'b0} ^ {11'd0, (fb ? Crc5Poly : 5'h00)};
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      crc_q <= 16'h0000;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/usb_tx_sequencer.sv
// USB full-speed packet sequencer: serialises SYNC, PID, token/data fields, CRC and EOP
// into a bit stream for the downstream bit stuffer, freezing whenever the stuffer holds.
module usb_tx_sequencer
  import usb_tx_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  usb_tx_sequencer_if.slave bus
);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  pkt_type_t   type_q, type_d;
  logic [3:0]  pid_q, pid_d;
  logic [10:0] tok_q, tok_d;
  logic [7:0]  byte_q, byte_d;
  logic        last_q, last_d;

  logic        adv, crc_init, crc_en, crc_mode16;
  logic [15:0] crc;
  logic [3:0]  crc_last, crc_idx;
  logic [7:0]  pid_bits;
  pkt_type_t   req_type;
  logic        tx_bit, tx_en, eop, busy, done, underrun, byte_ready;

  assign req_type   = pkt_type_t'(bus.pkt_type);
  assign adv        = ~bus.stuff_hold;
  assign pid_bits   = pid_byte(pid_q);
  assign crc_last   = (type_q == PktToken) ? 4'd4 : 4'd15;
  assign crc_idx    = crc_last - cnt_q;
  // The CRC is initialised on the start cycle, before type_q holds the new packet type.
  assign crc_mode16 = (state_q == StIdle) ? (req_type == PktData) : (type_q == PktData);

  usb_crc_gen u_crc (
    .clk    (clk),
    .rst    (rst),
    .init   (crc_init),
    .en     (crc_en),
    .mode16 (crc_mode16),
    .din    (tx_bit),
    .crc    (crc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      type_q  <= PktHandshake;
      pid_q   <= 4'd0;
      tok_q   <= 11'd0;
      byte_q  <= 8'd0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      type_q  <= type_d;
      pid_q   <= pid_d;
      tok_q   <= tok_d;
      byte_q  <= byte_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    type_d     = type_q;
    pid_d      = pid_q;
    tok_d      = tok_q;
    byte_d     = byte_q;
    last_d     = last_q;
    tx_bit     = 1'b1;
    tx_en      = 1'b0;
    eop        = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    underrun   = 1'b0;
    byte_ready = 1'b0;
    crc_init   = 1'b0;
    crc_en     = 1'b0;

    unique case (state_q)
      StIdle: begin
        busy = 1'b0;
        if (bus.start && (req_type != PktReserved)) begin
          state_d  = StSync;
          cnt_d    = 4'd0;
          type_d   = req_type;
          pid_d    = bus.pid;
          tok_d    = bus.tok_field;
          crc_init = 1'b1;
        end
      end
      StSync: begin
        tx_bit = SyncPattern[cnt_q[2:0]];
        tx_en  = adv;
        if (adv) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            state_d = StPid;
            cnt_d   = 4'd0;
          end
        end
      end
      StPid: begin
        tx_bit = pid_bits[cnt_q[2:0]];
        tx_en  = adv;
        if (adv) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            cnt_d = 4'd0;
            case (type_q)
              PktHandshake: state_d = StEop;
              PktToken:     state_d = StToken;
              default: begin
                if (bus.byte_valid) begin
                  state_d = StData;
                  byte_d  = bus.byte_data;
                  last_d  = bus.byte_last;
                end else begin
                  state_d = StCrc;
                end
              end
            endcase
          end
        end
      end
      StToken: begin
        tx_bit = tok_q[cnt_q];
        tx_en  = adv;
        crc_en = adv;
        if (adv) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == TokLastBit) begin
            state_d = StCrc;
            cnt_d   = 4'd0;
          end
        end
      end
      StData: begin
        tx_bit     = byte_q[cnt_q[2:0]];
        tx_en      = adv;
        crc_en     = adv;
        byte_ready = adv && (cnt_q == 4'd0);
        if (adv) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            cnt_d = 4'd0;
            if (last_q) begin
              state_d = StCrc;
            end else if (bus.byte_valid) begin
              byte_d = bus.byte_data;
              last_d = bus.byte_last;
            end else begin
              underrun = 1'b1;
              state_d  = StEop;
            end
          end
        end
      end
      StCrc: begin
        tx_bit = ~crc[crc_idx];
        tx_en  = adv;
        if (adv) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == crc_last) begin
            state_d = StEop;
            cnt_d   = 4'd0;
          end
        end
      end
      StEop: begin
        eop = 1'b1;
        if (cnt_q == 4'd0) begin
          cnt_d = 4'd1;
        end else begin
          done    = 1'b1;
          state_d = StIdle;
          cnt_d   = 4'd0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.tx_bit     = tx_bit;
  assign bus.tx_en      = tx_en;
  assign bus.eop        = eop;
  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.underrun   = underrun;
  assign bus.byte_ready = byte_ready;

endmodule

// File: tb/tb_usb_tx_sequencer.sv
// Self-checking bench for usb_tx_sequencer: directed packets plus randomized packets
// compared against a bit-list model of the USB packet format.
module tb_usb_tx_sequencer;

  logic clk = 1'b0;
  logic rst;

  usb_tx_sequencer_if bus ();

  usb_tx_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  logic exp_q[$];
  logic obs_q[$];
  logic [7:0] pay [0:15];

  function automatic void push_bits(input logic [15:0] v, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(v[i]);
  endfunction

  // Reference CRC: polynomial long division over exp_q[from..end], inverted, pushed MSB first.
  function automatic void push_crc(input int from, input int width);
    logic [15:0] r, poly, mask;
    logic        fb;
    mask = (width == 5) ? 16'h001F : 16'hFFFF;
    poly = (width == 5) ? 16'h0005 : 16'h8005;
    r    = mask;
    for (int i = from; i < exp_q.size(); i++) begin
      fb = r[width-1] ^ exp_q[i];
      r  = (r << 1) & mask;
      if (fb) r = r ^ poly;
    end
    r = ~r & mask;
    for (int i = width - 1; i >= 0; i--) exp_q.push_back(r[i]);
  endfunction

  // Builds the expected wire bits; returns expected byte_ready and underrun counts.
  task automatic build_model(input logic [1:0] ty, input logic [3:0] p, input logic [10:0] tok,
                             input int nbytes, input int navail,
                             output int e_ready, output int e_under);
    int s, nsent;
    exp_q.delete();
    e_ready = 0;
    e_under = 0;
    push_bits(16'h0080, 8);
    push_bits({8'h00, ~p, p}, 8);
    if (ty == 2'b01) begin
      s = exp_q.size();
      push_bits({5'h00, tok}, 11);
      push_crc(s, 5);
    end else if (ty == 2'b10) begin
      s     = exp_q.size();
      nsent = (navail < nbytes) ? navail : nbytes;
      for (int b = 0; b < nsent; b++) push_bits({8'h00, pay[b]}, 8);
      e_ready = nsent;
      if (navail > 0 && navail < nbytes) e_under = 1;
      else push_crc(s, 16);
    end
  endtask

  task automatic drive_src(input int src, input int nbytes, input int navail);
    bus.byte_valid = (src < navail) && (src < nbytes);
    bus.byte_data  = (src < 16) ? pay[src] : 8'h00;
    bus.byte_last  = (src == nbytes - 1);
  endtask

  task automatic run_packet(input logic [1:0] ty, input logic [3:0] p, input logic [10:0] tok,
                            input int nbytes, input int navail, input int hold_at,
                            input int e_ready, input int e_under, input string name);
    int   src, cyc, n_ready, n_under, n_eop, n_overlap, eop_at_done, bad_idx;
    bit   ready_seen, got_done, hold_pending, hold_ok;
    logic hold_bit;
    obs_q.delete();
    src = 0; cyc = 0; n_ready = 0; n_under = 0; n_eop = 0; n_overlap = 0; eop_at_done = -1;
    ready_seen = 0; got_done = 0; hold_pending = 0; hold_ok = 1; hold_bit = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.pkt_type = ty; bus.pid = p; bus.tok_field = tok;
    bus.stuff_hold = 1'b0;
    drive_src(src, nbytes, navail);
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL %s idle_busy: got %b want 0", name, bus.busy);
    end
    while (!got_done && cyc < 600) begin
      @(posedge clk); #1;
      // A start while busy must be ignored, together with the fields presented with it.
      bus.start = (cyc == 4);
      if (cyc == 4) begin
        bus.pid = ~p; bus.pkt_type = 2'b00; bus.tok_field = ~tok;
      end
      bus.stuff_hold = (cyc == hold_at);
      if (ready_seen) src++;
      ready_seen = 0;
      drive_src(src, nbytes, navail);
      @(negedge clk);
      if (hold_pending) begin
        if (bus.tx_bit !== hold_bit) hold_ok = 0;
        hold_pending = 0;
      end
      if (cyc == hold_at) begin
        if (bus.tx_en !== 1'b0) hold_ok = 0;
        hold_bit = bus.tx_bit; hold_pending = 1;
      end
      if (bus.tx_en === 1'b1) obs_q.push_back(bus.tx_bit);
      if (bus.tx_en === 1'b1 && bus.eop === 1'b1) n_overlap++;
      if (bus.byte_ready === 1'b1) begin n_ready++; ready_seen = 1; end
      if (bus.underrun === 1'b1) n_under++;
      if (bus.eop === 1'b1) n_eop++;
      if (bus.done === 1'b1) begin got_done = 1; eop_at_done = n_eop; end
      cyc++;
    end
    bus.start = 1'b0; bus.stuff_hold = 1'b0;
    checks++;
    if (!got_done) begin
      errors++; $display("FAIL %s timeout: no done after %0d cycles", name, cyc);
    end
    bad_idx = -1;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      if (bad_idx < 0 && obs_q[i] !== exp_q[i]) bad_idx = i;
    checks++;
    if (obs_q.size() != exp_q.size() || bad_idx >= 0) begin
      errors++;
      $display("FAIL %s stream: got %0d bits (first diff at %0d) want %0d bits", name,
               obs_q.size(), bad_idx, exp_q.size());
    end
    checks++;
    if (n_ready != e_ready) begin
      errors++; $display("FAIL %s byte_ready: got %0d want %0d", name, n_ready, e_ready);
    end
    checks++;
    if (n_under != e_under) begin
      errors++; $display("FAIL %s underrun: got %0d want %0d", name, n_under, e_under);
    end
    checks++;
    if (n_eop != 2 || eop_at_done != 2 || n_overlap != 0) begin
      errors++;
      $display("FAIL %s eop: got %0d cycles done_at %0d overlap %0d want 2 2 0", name, n_eop,
               eop_at_done, n_overlap);
    end
    if (hold_at >= 0) begin
      checks++;
      if (!hold_ok) begin
        errors++; $display("FAIL %s hold_freeze: got bad freeze want tx_en=0 and held bit", name);
      end
    end
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL %s after_done: got busy=%b done=%b want 0 0", name, bus.busy, bus.done);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    logic [6:0] got;
    got = {bus.tx_bit, bus.tx_en, bus.eop, bus.busy, bus.done, bus.underrun, bus.byte_ready};
    checks++;
    if (got !== 7'b1000000) begin
      errors++; $display("FAIL %s reset_outputs: got %b want 1000000", name, got);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.start = 1'b0; bus.pkt_type = 2'b00; bus.pid = 4'h0; bus.tok_field = 11'd0;
    bus.byte_data = 8'h00; bus.byte_valid = 1'b0; bus.byte_last = 1'b0; bus.stuff_hold = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("post_reset_idle");
  endtask

  task automatic test_ack();
    exp_q.delete();
    push_bits(16'h0080, 8);
    push_bits(16'h00D2, 8);
    run_packet(2'b00, 4'b0010, 11'd0, 1, 0, -1, 0, 0, "ack");
  endtask

  task automatic test_setup_token();
    exp_q.delete();
    push_bits(16'h0080, 8);
    push_bits(16'h002D, 8);
    push_bits(16'h0000, 8);
    push_bits(16'h0010, 8);
    run_packet(2'b01, 4'b1101, 11'd0, 1, 0, -1, 0, 0, "setup");
  endtask

  task automatic test_zero_length();
    exp_q.delete();
    push_bits(16'h0080, 8);
    push_bits(16'h00C3, 8);
    push_bits(16'h0000, 16);
    run_packet(2'b10, 4'b0011, 11'd0, 1, 0, -1, 0, 0, "data0_zlp");
  endtask

  task automatic test_two_bytes_hold();
    int er, eu;
    pay[0] = 8'($urandom); pay[1] = 8'($urandom);
    build_model(2'b10, 4'b0011, 11'd0, 2, 2, er, eu);
    run_packet(2'b10, 4'b0011, 11'd0, 2, 2, 19, er, eu, "data0_two_hold");
  endtask

  task automatic test_underrun();
    int er, eu;
    for (int i = 0; i < 3; i++) pay[i] = 8'($urandom);
    build_model(2'b10, 4'b1011, 11'd0, 3, 1, er, eu);
    run_packet(2'b10, 4'b1011, 11'd0, 3, 1, -1, er, eu, "underrun");
  endtask

  task automatic test_reserved();
    int n_busy;
    n_busy = 0;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.pkt_type = 2'b11; bus.pid = 4'h5;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (bus.busy !== 1'b0 || bus.tx_en !== 1'b0) n_busy++;
    end
    checks++;
    if (n_busy != 0) begin
      errors++; $display("FAIL reserved_ignored: got %0d busy cycles want 0", n_busy);
    end
  endtask

  task automatic test_reset_mid();
    int er, eu, n_bad;
    n_bad = 0;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.pkt_type = 2'b10; bus.pid = 4'b0011;
    bus.byte_valid = 1'b1; bus.byte_last = 1'b0; bus.byte_data = 8'hA5;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (20) @(posedge clk);
    #1 rst = 1'b0;
    #1 check_reset_outputs("reset_mid");
    repeat (2) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.eop !== 1'b0) n_bad++;
    end
    checks++;
    if (n_bad != 0) begin
      errors++; $display("FAIL reset_mid_no_eop: got %0d eop/done cycles want 0", n_bad);
    end
    bus.byte_valid = 1'b0;
    rst = 1'b1;
    pay[0] = 8'($urandom);
    build_model(2'b10, 4'b0011, 11'd0, 1, 1, er, eu);
    run_packet(2'b10, 4'b0011, 11'd0, 1, 1, -1, er, eu, "after_reset_clean");
  endtask

  task automatic test_random();
    int er, eu, nb, na, hold, sel;
    logic [1:0]  ty;
    logic [3:0]  p;
    logic [10:0] tok;
    for (int k = 0; k < 8; k++) begin
      ty  = 2'($urandom_range(0, 2));
      p   = 4'($urandom);
      tok = 11'($urandom);
      nb  = int'($urandom_range(1, 4));
      sel = int'($urandom_range(0, 3));
      na  = (sel == 0) ? 0 : (sel == 1) ? int'($urandom_range(1, nb)) : nb;
      for (int i = 0; i < 16; i++) pay[i] = 8'($urandom);
      build_model(ty, p, tok, nb, na, er, eu);
      hold = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, exp_q.size() - 1)) : -1;
      run_packet(ty, p, tok, nb, na, hold, er, eu, $sformatf("random%0d", k));
    end
  endtask

  initial begin
    test_reset();
    test_ack();
    test_setup_token();
    test_zero_length();
    test_two_bytes_hold();
    test_underrun();
    test_reserved();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
